relm_i2c_master: RTL and testbench

- Byte-level I2C master peripheral on one RELM push port and one pop port.
- Replaces the single-bit SCL/SDA bit-bang peripheral with a hardware sequencer:
  - The CPU pushes one command word per byte.
  - The block generates optional START, 8 data bits, ACK bit and optional STOP on open-drain SCL/SDA.
  - The CPU pops status and received data.
- Sits between the RELM core push/pop buses and the HDMI-transmitter I2C pins.

---
 rtl/relm_i2c_master.sv | 224 ++++++++++++++++++++++
 tb/tb_relm_i2c_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relm_i2c_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// relm_i2c_master : byte-level I2C master sequencer on RELM push/pop ports
// Rev 1.0
// ---------------------------------------------------------------------------
module relm_i2c_master #(
   parameter int WD  = 32,
   parameter int DIV = 125
) (
   input  logic          clk,
   input  logic          rst_in,
   input  logic [WD:0]   push_d,
   output logic          push_retry,
   input  logic [WD:0]   pop_d,
   output logic [WD:0]   pop_q,
   input  logic          scl_in,
   input  logic          sda_in,
   output logic          scl_out,
   output logic          sda_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BIT   = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

   state_t      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [3:0]  bit_q, bit_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  tx_q, tx_d;
   logic        stop_q, stop_d;
   logic        rd_q, rd_d;
   logic        mack_q, mack_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ack_err_q, ack_err_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  sh_q, sh_d;
   logic        nack_q, nack_d;
   logic        scl_q, scl_d;
   logic        sda_q, sda_d;
   logic [1:0]  scl_s_q;
   logic [1:0]  sda_s_q;

   logic        stretch;
   logic        adv;
   logic        finish;
   logic        bit_val;
   logic        unused_bits;

   assign unused_bits = ^{push_d[WD-1:12], pop_d[WD-1:0]};

   assign push_retry = busy_q;
   assign scl_out    = scl_q;
   assign sda_out    = sda_q;

   always_comb begin
      pop_q         = '0;
      pop_q[WD-1]   = busy_q;
      pop_q[WD-2]   = done_q;
      pop_q[8]      = ack_err_q;
      pop_q[7:0]    = rx_q;
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         scl_s_q <= 2'b11;
         sda_s_q <= 2'b11;
      end else begin
         scl_s_q <= {scl_s_q[0], scl_in};
         sda_s_q <= {sda_s_q[0], sda_in};
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      stop_d    = stop_q;
      rd_d      = rd_q;
      mack_d    = mack_q;
      busy_d    = busy_q;
      done_d    = done_q;
      ack_err_d = ack_err_q;
      rx_d      = rx_q;
      sh_d      = sh_q;
      nack_d    = nack_q;
      scl_d     = scl_q;
      sda_d     = sda_q;
      finish    = 1'b0;
      bit_val   = 1'b1;

      // A slave holding SCL low while we release it freezes the phase timer
      stretch = scl_q && !scl_s_q[1];
      adv     = (cnt_q == CNT_LAST) && !stretch;

      if (pop_d[WD]) done_d = 1'b0;

      if (state_q == S_IDLE) begin
         if (push_d[WD] && !busy_q) begin
            tx_d      = push_d[7:0];
            stop_d    = push_d[9];
            rd_d      = push_d[10];
            mack_d    = push_d[11];
            busy_d    = 1'b1;
            done_d    = 1'b0;
            ack_err_d = 1'b0;
            nack_d    = 1'b0;
            state_d   = push_d[8] ? S_START : S_BIT;
            phase_d   = 2'd0;
            bit_d     = 4'd0;
            cnt_d     = 16'd0;
         end
      end else begin
         if (stretch || (cnt_q == CNT_LAST)) cnt_d = 16'd0;
         else                                cnt_d = cnt_q + 16'd1;

         if (adv) begin
            phase_d = phase_q + 2'd1;
            unique case (state_q)
               S_START: begin
                  if (phase_q == 2'd3) begin
                     state_d = S_BIT;
                     bit_d   = 4'd0;
                  end
               end
               S_BIT: begin
                  if (phase_q == 2'd2) begin
                     if (bit_q != 4'd8) sh_d   = {sh_q[6:0], sda_s_q[1]};
                     else if (!rd_q)    nack_d = sda_s_q[1];
                  end
                  if (phase_q == 2'd3) begin
                     if (bit_q != 4'd8)  bit_d   = bit_q + 4'd1;
                     else if (stop_q)    state_d = S_STOP;
                     else                finish  = 1'b1;
                  end
               end
               S_STOP: begin
                  if (phase_q == 2'd3) finish = 1'b1;
               end
               default: ;
            endcase
         end

         if (finish) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rx_d      = sh_q;
            ack_err_d = nack_q;
         end
      end

      if (bit_d == 4'd8) bit_val = rd_d ? mack_d : 1'b1;
      else               bit_val = rd_d ? 1'b1 : tx_d[~bit_d[2:0]];

      // Pin levels are registered: they follow the phase being entered
      unique case (state_d)
         S_START: begin
            scl_d = phase_d[0] ^ phase_d[1];
            sda_d = !phase_d[1];
         end
         S_BIT: begin
            scl_d = phase_d[1];
            sda_d = bit_val;
         end
         S_STOP: begin
            scl_d = |phase_d;
            sda_d = phase_d[1];
         end
         S_IDLE: begin
            if (finish && !stop_q) scl_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         phase_q   <= 2'd0;
         bit_q     <= 4'd0;
         cnt_q     <= 16'd0;
         tx_q      <= 8'd0;
         stop_q    <= 1'b0;
         rd_q      <= 1'b0;
         mack_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         rx_q      <= 8'd0;
         sh_q      <= 8'd0;
         nack_q    <= 1'b0;
         scl_q     <= 1'b1;
         sda_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         stop_q    <= stop_d;
         rd_q      <= rd_d;
         mack_q    <= mack_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         rx_q      <= rx_d;
         sh_q      <= sh_d;
         nack_q    <= nack_d;
         scl_q     <= scl_d;
         sda_q     <= sda_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_relm_i2c_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_relm_i2c_master : randomized/directed bench with a bit-level I2C slave
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_relm_i2c_master;

   localparam int WD   = 32;
   localparam int DIV  = 4;
   localparam int NONE = -99;

   logic          clk = 1'b0;
   logic          rst_in;
   logic [WD:0]   push_d;
   logic          push_retry;
   logic [WD:0]   pop_d;
   logic [WD:0]   pop_q;
   logic          scl_in;
   logic          sda_in;
   logic          scl_out;
   logic          sda_out;
   logic          slave_sda;

   assign sda_in = sda_out & slave_sda;

   always #5 clk = ~clk;

   relm_i2c_master #(.WD(WD), .DIV(DIV)) dut (
      .clk        (clk),
      .rst_in     (rst_in),
      .push_d     (push_d),
      .push_retry (push_retry),
      .pop_d      (pop_d),
      .pop_q      (pop_q),
      .scl_in     (scl_in),
      .sda_in     (sda_in),
      .scl_out    (scl_out),
      .sda_out    (sda_out)
   );

   int errors = 0;
   int checks = 0;

   logic        obs_rise[$];
   int          obs_cycles;
   logic [WD:0] obs_pop;
   logic        obs_scl, obs_sda, obs_retry;

   logic        exp_rise[$];
   int          exp_cycles;
   logic [WD:0] exp_pop;
   logic        exp_scl, exp_sda;

   // Reference: what one byte transaction must look like on the wire
   task automatic model_xfer(input logic [11:0] cmd, input logic [7:0] sbyte,
                             input logic sack, input int stretch_len);
      logic st, sp, rd, mk, aerr;
      logic [7:0] rx;
      st = cmd[8]; sp = cmd[9]; rd = cmd[10]; mk = cmd[11];
      exp_rise.delete();
      if (st) exp_rise.push_back(1'b1);
      for (int k = 0; k < 8; k++) exp_rise.push_back(rd ? 1'b1 : cmd[7-k]);
      exp_rise.push_back(rd ? mk : 1'b1);
      if (sp) exp_rise.push_back(1'b0);
      exp_cycles = (4 * int'(st) + 36 + 4 * int'(sp)) * DIV + stretch_len;
      rx   = rd ? sbyte : cmd[7:0];
      aerr = !rd && sack;
      exp_pop         = '0;
      exp_pop[WD-2]   = 1'b1;
      exp_pop[8]      = aerr;
      exp_pop[7:0]    = rx;
      exp_scl = sp;
      exp_sda = sp ? 1'b1 : (rd ? mk : 1'b1);
   endtask

   function automatic logic slave_val(input logic [11:0] cmd, input logic [7:0] sbyte,
                                      input logic sack, input int k);
      if (k < 0 || k > 8) return 1'b1;
      if (k == 8) return cmd[10] ? 1'b1 : sack;
      return cmd[10] ? sbyte[7-k] : 1'b1;
   endfunction

   function automatic bit rise_match();
      if (obs_rise.size() != exp_rise.size()) return 1'b0;
      foreach (exp_rise[i]) if (obs_rise[i] !== exp_rise[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Pushes one command and plays the slave until busy drops (or abort)
   task automatic do_xfer(input logic [11:0] cmd, input logic [7:0] sbyte, input logic sack,
                          input int stretch_bit, input int stretch_len,
                          input int inj_at, input int pop_at, input int abort_bit);
      int   rcnt, st_wait, st_low, ab_wait, k;
      logic prev_scl, start;
      rcnt = 0; st_wait = 0; st_low = 0; ab_wait = 0;
      start = cmd[8];
      obs_rise.delete(); obs_cycles = -1; obs_retry = 1'b0;
      @(negedge clk);
      prev_scl = scl_out;
      push_d = '0; push_d[WD] = 1'b1; push_d[11:0] = cmd;
      slave_sda = slave_val(cmd, sbyte, sack, start ? -1 : 0);
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         push_d = '0;
         pop_d  = '0;
         if (n == inj_at) begin
            push_d[WD] = 1'b1; push_d[11:0] = 12'hF5A;
            obs_retry = push_retry;
         end
         if (n == pop_at) pop_d[WD] = 1'b1;
         if (st_wait > 0) begin
            st_wait--;
            if (st_wait == 0) begin scl_in = 1'b0; st_low = stretch_len; end
         end else if (st_low > 0) begin
            st_low--;
            if (st_low == 0) scl_in = 1'b1;
         end
         if (ab_wait > 0) begin
            ab_wait--;
            if (ab_wait == 0) begin
               rst_in = 1'b1;
               @(negedge clk);
               obs_pop = pop_q; obs_scl = scl_out; obs_sda = sda_out; obs_retry = push_retry;
               rst_in = 1'b0; slave_sda = 1'b1;
               return;
            end
         end
         if (scl_out && !prev_scl) begin
            obs_rise.push_back(sda_out);
            rcnt++;
         end
         if (!scl_out && prev_scl) begin
            k = rcnt - int'(start);
            slave_sda = slave_val(cmd, sbyte, sack, k);
            if (k == stretch_bit) st_wait = 2 * DIV - 2;
            if (k == abort_bit)   ab_wait = DIV;
         end
         prev_scl = scl_out;
         if (!pop_q[WD-1]) begin obs_cycles = n; break; end
      end
      pop_d = '0;
      obs_pop = pop_q; obs_scl = scl_out; obs_sda = sda_out;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      repeat (3) @(negedge clk);
      rst_in = 1'b0;
      @(negedge clk);
      checks++; if (pop_q !== '0) begin errors++; $display("FAIL reset_pop: got %h expected 0", pop_q); end
      checks++; if (push_retry !== 1'b0) begin errors++; $display("FAIL reset_retry: got %b expected 0", push_retry); end
      checks++; if ({scl_out, sda_out} !== 2'b11) begin errors++; $display("FAIL reset_lines: got %b expected 11", {scl_out, sda_out}); end
   endtask

   task automatic test_write_ack();
      model_xfer(12'h3A5, 8'h00, 1'b0, 0);
      do_xfer(12'h3A5, 8'h00, 1'b0, NONE, 0, NONE, NONE, NONE);
      checks++; if (obs_cycles !== 176) begin errors++; $display("FAIL a5_cycles: got %0d expected 176", obs_cycles); end
      checks++; if (!rise_match()) begin errors++; $display("FAIL a5_rise: got %p expected %p", obs_rise, exp_rise); end
      checks++; if (obs_pop !== exp_pop) begin errors++; $display("FAIL a5_pop: got %h expected %h", obs_pop, exp_pop); end
      checks++; if ({obs_scl, obs_sda} !== 2'b11) begin errors++; $display("FAIL a5_lines: got %b expected 11", {obs_scl, obs_sda}); end
   endtask

   task automatic test_write_nack();
      model_xfer(12'h33C, 8'h00, 1'b1, 0);
      do_xfer(12'h33C, 8'h00, 1'b1, NONE, 0, NONE, NONE, NONE);
      checks++; if (obs_pop[8:0] !== 9'h13C) begin errors++; $display("FAIL nack_pop: got %h expected 13c", obs_pop[8:0]); end
      checks++; if (obs_pop !== exp_pop) begin errors++; $display("FAIL nack_word: got %h expected %h", obs_pop, exp_pop); end
      checks++; if (obs_cycles !== exp_cycles) begin errors++; $display("FAIL nack_cycles: got %0d expected %0d", obs_cycles, exp_cycles); end
   endtask

   task automatic test_read();
      model_xfer(12'hF00, 8'h5A, 1'b0, 0);
      do_xfer(12'hF00, 8'h5A, 1'b0, NONE, 0, NONE, NONE, NONE);
      checks++; if (obs_pop[7:0] !== 8'h5A) begin errors++; $display("FAIL read_rx: got %h expected 5a", obs_pop[7:0]); end
      checks++; if (obs_pop !== exp_pop) begin errors++; $display("FAIL read_pop: got %h expected %h", obs_pop, exp_pop); end
      checks++; if (!rise_match()) begin errors++; $display("FAIL read_rise: got %p expected %p", obs_rise, exp_rise); end
      checks++; if ({obs_scl, obs_sda} !== 2'b11) begin errors++; $display("FAIL read_lines: got %b expected 11", {obs_scl, obs_sda}); end
   endtask

   task automatic test_stretch();
      model_xfer(12'h396, 8'h00, 1'b0, 50);
      do_xfer(12'h396, 8'h00, 1'b0, 3, 50, NONE, NONE, NONE);
      checks++; if (obs_cycles !== 226) begin errors++; $display("FAIL stretch_cycles: got %0d expected 226", obs_cycles); end
      checks++; if (!rise_match()) begin errors++; $display("FAIL stretch_rise: got %p expected %p", obs_rise, exp_rise); end
      checks++; if (obs_pop !== exp_pop) begin errors++; $display("FAIL stretch_pop: got %h expected %h", obs_pop, exp_pop); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] cmds[3]  = '{12'h1C3, 12'h400, 12'h281};
      logic [7:0]  bytes[3] = '{8'h00, 8'h96, 8'h00};
      for (int i = 0; i < 3; i++) begin
         model_xfer(cmds[i], bytes[i], 1'b0, 0);
         do_xfer(cmds[i], bytes[i], 1'b0, NONE, 0, NONE, NONE, NONE);
         checks++; if (obs_cycles !== exp_cycles) begin errors++; $display("FAIL b2b_cycles[%0d]: got %0d expected %0d", i, obs_cycles, exp_cycles); end
         checks++; if (!rise_match()) begin errors++; $display("FAIL b2b_rise[%0d]: got %p expected %p", i, obs_rise, exp_rise); end
         checks++; if (obs_pop !== exp_pop) begin errors++; $display("FAIL b2b_pop[%0d]: got %h expected %h", i, obs_pop, exp_pop); end
         checks++; if ({obs_scl, obs_sda} !== {exp_scl, exp_sda}) begin errors++; $display("FAIL b2b_lines[%0d]: got %b expected %b", i, {obs_scl, obs_sda}, {exp_scl, exp_sda}); end
      end
   endtask

   task automatic test_busy_push();
      model_xfer(12'h3E1, 8'h00, 1'b0, 0);
      do_xfer(12'h3E1, 8'h00, 1'b0, NONE, 0, 20, NONE, NONE);
      checks++; if (obs_retry !== 1'b1) begin errors++; $display("FAIL busy_retry: got %b expected 1", obs_retry); end
      checks++; if (obs_pop !== exp_pop) begin errors++; $display("FAIL busy_pop: got %h expected %h", obs_pop, exp_pop); end
      repeat (3) @(negedge clk);
      checks++; if (pop_q[WD-1] !== 1'b0) begin errors++; $display("FAIL busy_ignored: got busy %b expected 0", pop_q[WD-1]); end
   endtask

   task automatic test_done_race();
      model_xfer(12'h3C8, 8'h00, 1'b0, 0);
      do_xfer(12'h3C8, 8'h00, 1'b0, NONE, 0, NONE, exp_cycles - 1, NONE);
      checks++; if (obs_pop[WD-2] !== 1'b1) begin errors++; $display("FAIL race_done: got %b expected 1", obs_pop[WD-2]); end
      @(negedge clk); pop_d[WD] = 1'b1;
      @(negedge clk); pop_d = '0;
      checks++; if (pop_q[WD-2] !== 1'b0) begin errors++; $display("FAIL pop_clear: got %b expected 0", pop_q[WD-2]); end
   endtask

   task automatic test_random();
      logic [11:0] cmd;
      logic [7:0]  sb;
      logic        sk;
      for (int i = 0; i < 8; i++) begin
         cmd = 12'($urandom_range(0, 4095));
         sb  = 8'($urandom_range(0, 255));
         sk  = 1'($urandom_range(0, 1));
         model_xfer(cmd, sb, sk, 0);
         do_xfer(cmd, sb, sk, NONE, 0, NONE, NONE, NONE);
         checks++; if (obs_cycles !== exp_cycles) begin errors++; $display("FAIL rnd_cycles[%0d] cmd=%h: got %0d expected %0d", i, cmd, obs_cycles, exp_cycles); end
         checks++; if (!rise_match()) begin errors++; $display("FAIL rnd_rise[%0d] cmd=%h: got %p expected %p", i, cmd, obs_rise, exp_rise); end
         checks++; if (obs_pop !== exp_pop) begin errors++; $display("FAIL rnd_pop[%0d] cmd=%h: got %h expected %h", i, cmd, obs_pop, exp_pop); end
         checks++; if ({obs_scl, obs_sda} !== {exp_scl, exp_sda}) begin errors++; $display("FAIL rnd_lines[%0d] cmd=%h: got %b expected %b", i, cmd, {obs_scl, obs_sda}, {exp_scl, exp_sda}); end
      end
   endtask

   task automatic test_reset_mid();
      do_xfer(12'h3A5, 8'h00, 1'b0, NONE, 0, NONE, NONE, 4);
      checks++; if ({obs_scl, obs_sda} !== 2'b11) begin errors++; $display("FAIL abort_lines: got %b expected 11", {obs_scl, obs_sda}); end
      checks++; if (obs_pop[WD-1:WD-2] !== 2'b00) begin errors++; $display("FAIL abort_flags: got %b expected 00", obs_pop[WD-1:WD-2]); end
      checks++; if (obs_retry !== 1'b0) begin errors++; $display("FAIL abort_retry: got %b expected 0", obs_retry); end
   endtask

   initial begin
      rst_in = 1'b1; push_d = '0; pop_d = '0; scl_in = 1'b1; slave_sda = 1'b1;
      test_reset();
      test_write_ack();
      test_write_nack();
      test_read();
      test_stretch();
      test_back_to_back();
      test_busy_push();
      test_done_race();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
